// File: rtl/pipe_perf_monitor_pkg.sv
// Shared types and constants for the pipeline performance monitor.
// Holds the FSM state encoding and the snapshot readout select codes.
package pipe_perf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_CYCLE  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_STALL  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_FLUSH  = 2'd2;
    localparam logic [SEL_W-1:0] SEL_RETIRE = 2'd3;

    localparam int NUM_CNT = 4;

endpackage

// File: rtl/pipe_perf_monitor_if.sv
// Event and snapshot bus between the CPU pipeline side and the perf monitor.
// The master drives run/event/snapshot requests; the slave (monitor) answers.
interface pipe_perf_monitor_if #(
    parameter int CNT_W = 32
);
    import pipe_perf_pkg::*;

    logic             start_i;
    logic             stall_i;
    logic             flush_i;
    logic             retire_i;
    logic             snap_req_i;
    logic [SEL_W-1:0] snap_sel_i;
    logic             snap_valid_o;
    logic [CNT_W-1:0] snap_data_o;
    logic             halt_o;
    logic             running_o;

    modport master (
        output start_i,
        output stall_i,
        output flush_i,
        output retire_i,
        output snap_req_i,
        output snap_sel_i,
        input  snap_valid_o,
        input  snap_data_o,
        input  halt_o,
        input  running_o
    );

    modport slave (
        input  start_i,
        input  stall_i,
        input  flush_i,
        input  retire_i,
        input  snap_req_i,
        input  snap_sel_i,
        output snap_valid_o,
        output snap_data_o,
        output halt_o,
        output running_o
    );

endinterface

// File: rtl/pipe_perf_monitor_sat_counter.sv
// Saturating up-counter: increments by inc_i when en_i is set, sticks at all-ones.
// Synchronous clear on rst_i.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Counter register with saturation at all-ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= CNT_ZERO;
        end else if (en_i && inc_i && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o = cnt_r;

endmodule

// File: rtl/pipe_perf_monitor.sv
// Pipeline performance monitor: counts run cycles, stalls, flushes and retires,
// halts after a cycle budget and serves coherent shadow snapshots on request.
module pipe_perf_monitor
    import pipe_perf_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 30
) (
    input logic               clk_i,
    input logic               rst_i,
    pipe_perf_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   BUDGET   = (CNT_W+1)'(MAX_CYCLES);
    localparam logic [CNT_W:0]   ONE_EXT  = {{CNT_W{1'b0}}, 1'b1};

    state_e           state_r;
    state_e           state_s;
    logic             count_en_s;
    logic [CNT_W:0]   cycle_next_s;
    logic             halt_hit_s;
    logic             running_s;
    logic             halt_s;
    logic             running_r;
    logic             halt_r;
    logic             snap_valid_r;
    logic [CNT_W-1:0] snap_data_s;
    logic [NUM_CNT-1:0] inc_s;
    logic [CNT_W-1:0] live_s   [NUM_CNT];
    logic [CNT_W-1:0] shadow_r [NUM_CNT];

    assign count_en_s = (state_r == RUN) && bus.start_i;

    // Increment sources indexed by the readout select codes.
    assign inc_s = {bus.retire_i, bus.flush_i, bus.stall_i, 1'b1};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (count_en_s),
            .inc_i (inc_s[g]),
            .cnt_o (live_s[g])
        );
    end

    // The budget is hit on the counting edge whose increment lands on MAX_CYCLES.
    assign cycle_next_s = {1'b0, live_s[SEL_CYCLE]} + ONE_EXT;
    assign halt_hit_s   = (MAX_CYCLES != 0) && (live_s[SEL_CYCLE] != CNT_MAX) &&
                          (cycle_next_s == BUDGET);

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start_i) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (!bus.start_i) begin
                    state_s = IDLE;
                end else if (halt_hit_s) begin
                    state_s = HALT;
                end else begin
                    state_s = RUN;
                end
            end
            HALT: begin
                state_s = HALT;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM output decode, taken from the next state so the registered flags track state_r.
    always_comb begin
        running_s = 1'b0;
        halt_s    = 1'b0;
        case (state_s)
            RUN: begin
                running_s = 1'b1;
            end
            HALT: begin
                halt_s = 1'b1;
            end
            default: begin
                running_s = 1'b0;
                halt_s    = 1'b0;
            end
        endcase
    end

    // Registered status flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            running_r <= 1'b0;
            halt_r    <= 1'b0;
        end else begin
            running_r <= running_s;
            halt_r    <= halt_s;
        end
    end

    // Shadow capture takes pre-edge live values, so a same-edge increment lands in the next snapshot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            snap_valid_r <= 1'b0;
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow_r[i] <= CNT_ZERO;
            end
        end else begin
            snap_valid_r <= bus.snap_req_i;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (bus.snap_req_i) begin
                    shadow_r[i] <= live_s[i];
                end else begin
                    shadow_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Readout mux over the shadow registers.
    always_comb begin
        snap_data_s = shadow_r[SEL_CYCLE];
        case (bus.snap_sel_i)
            SEL_CYCLE:  snap_data_s = shadow_r[SEL_CYCLE];
            SEL_STALL:  snap_data_s = shadow_r[SEL_STALL];
            SEL_FLUSH:  snap_data_s = shadow_r[SEL_FLUSH];
            SEL_RETIRE: snap_data_s = shadow_r[SEL_RETIRE];
            default:    snap_data_s = shadow_r[SEL_CYCLE];
        endcase
    end

    assign bus.snap_valid_o = snap_valid_r;
    assign bus.snap_data_o  = snap_data_s;
    assign bus.halt_o       = halt_r;
    assign bus.running_o    = running_r;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor: a behavioural model pushes expected
// snapshots on each request; each scenario task pops and compares on snap_valid_o.
module tb_pipe_perf_monitor;
    import pipe_perf_pkg::*;

    typedef logic [3:0][31:0] snap_t;

    logic       clk = 1'b0;
    logic       rst, start, stall, flush, retire, req;
    logic [1:0] sel;
    bit         use4;

    int n_total = 0;
    int n_pass  = 0;

    snap_t      exp_q[$];
    snap_t      m_cnt;
    logic [31:0] m_sat;
    longint     m_max;
    state_e     m_state;

    always #10 clk = ~clk;

    pipe_perf_monitor_if #(.CNT_W(32)) bus32 ();
    pipe_perf_monitor_if #(.CNT_W(4))  bus4 ();

    assign bus32.start_i    = start;
    assign bus32.stall_i    = stall;
    assign bus32.flush_i    = flush;
    assign bus32.retire_i   = retire;
    assign bus32.snap_req_i = req;
    assign bus32.snap_sel_i = sel;
    assign bus4.start_i     = start;
    assign bus4.stall_i     = stall;
    assign bus4.flush_i     = flush;
    assign bus4.retire_i    = retire;
    assign bus4.snap_req_i  = req;
    assign bus4.snap_sel_i  = sel;

    pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(30)) dut32 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus32)
    );

    pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    logic        valid_w, halt_w, running_w;
    logic [31:0] data_w;
    assign valid_w   = use4 ? bus4.snap_valid_o : bus32.snap_valid_o;
    assign halt_w    = use4 ? bus4.halt_o       : bus32.halt_o;
    assign running_w = use4 ? bus4.running_o    : bus32.running_o;
    assign data_w    = use4 ? {28'd0, bus4.snap_data_o} : bus32.snap_data_o;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc, input logic [31:0] lim);
        if (inc && (v != lim)) return v + 32'd1;
        return v;
    endfunction

    // One clock edge: drive inputs on the falling edge, advance the model, observe 1 unit after the rising edge.
    task automatic tick(input logic r, input logic s, input logic sl, input logic fl, input logic rt, input logic rq);
        @(negedge clk);
        rst = r; start = s; stall = sl; flush = fl; retire = rt; req = rq;
        if (r) begin
            m_state = IDLE;
            m_cnt   = '0;
            exp_q.delete();
        end else begin
            if (rq) exp_q.push_back(m_cnt);
            case (m_state)
                IDLE: if (s) m_state = RUN;
                RUN: begin
                    if (!s) begin
                        m_state = IDLE;
                    end else begin
                        m_cnt[0] = sat_inc(m_cnt[0], 1'b1, m_sat);
                        m_cnt[1] = sat_inc(m_cnt[1], sl, m_sat);
                        m_cnt[2] = sat_inc(m_cnt[2], fl, m_sat);
                        m_cnt[3] = sat_inc(m_cnt[3], rt, m_sat);
                        if (m_max != 0 && longint'(m_cnt[0]) == m_max) m_state = HALT;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample(output snap_t obs);
        for (int k = 0; k < 4; k++) begin
            sel = k[1:0];
            #1;
            obs[k] = data_w;
        end
    endtask

    task automatic test_reset();
        snap_t obs;
        use4 = 1'b0; m_sat = 32'hFFFF_FFFF; m_max = 30;
        tick(1, 0, 0, 0, 0, 0);
        n_total++; if (halt_w !== 1'b0) $display("FAIL reset_halt: got %b expected 0", halt_w); else n_pass++;
        n_total++; if (running_w !== 1'b0) $display("FAIL reset_running: got %b expected 0", running_w); else n_pass++;
        n_total++; if (valid_w !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_w); else n_pass++;
        sample(obs);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (obs[k] !== 32'd0) $display("FAIL reset_shadow%0d: got %0d expected 0", k, obs[k]); else n_pass++;
        end
    endtask

    task automatic test_count_halt();
        snap_t obs, e;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 1);
        n_total++; if (valid_w !== 1'b1) $display("FAIL cnt10_valid: got %b expected 1", valid_w); else n_pass++;
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[0] !== e[0] || obs[0] !== 32'd10) $display("FAIL cnt10_cycle: got %0d expected %0d", obs[0], e[0]); else n_pass++;
        for (int i = 0; i < 22; i++) begin
            tick(0, 1, 0, 0, 0, 0);
            n_total++;
            if (halt_w !== (m_state == HALT)) $display("FAIL halt_edge%0d: got %b expected %b", i, halt_w, m_state == HALT); else n_pass++;
            n_total++;
            if (running_w !== (m_state == RUN)) $display("FAIL running_edge%0d: got %b expected %b", i, running_w, m_state == RUN); else n_pass++;
        end
        tick(0, 1, 1, 1, 1, 1);
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[0] !== e[0] || obs[0] !== 32'd30) $display("FAIL halt_freeze_cycle: got %0d expected %0d", obs[0], e[0]); else n_pass++;
        n_total++; if (halt_w !== 1'b1) $display("FAIL halt_hold: got %b expected 1", halt_w); else n_pass++;
    endtask

    task automatic test_events();
        snap_t obs, e;
        logic [11:0] st_p, fl_p, rt_p;
        st_p = 12'b000100100001;
        fl_p = 12'b010000100000;
        rt_p = 12'b101101010011;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick(0, 1, st_p[i], fl_p[i], rt_p[i], 0);
        tick(0, 1, 0, 0, 0, 1);
        n_total++; if (valid_w !== 1'b1) $display("FAIL events_valid: got %b expected 1", valid_w); else n_pass++;
        sample(obs);
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (obs[k] !== e[k]) $display("FAIL events_sel%0d: got %0d expected %0d", k, obs[k], e[k]); else n_pass++;
        end
    endtask

    task automatic test_pause();
        snap_t obs, e;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, (i == 0 || i == 2), 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 1, 0, 0, 0);
            n_total++; if (running_w !== 1'b0) $display("FAIL pause_running%0d: got %b expected 0", i, running_w); else n_pass++;
        end
        tick(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, (i == 3), 0, 0, 0);
        tick(0, 1, 0, 0, 0, 1);
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[0] !== e[0] || obs[0] !== 32'd10) $display("FAIL pause_cycle: got %0d expected %0d", obs[0], e[0]); else n_pass++;
        n_total++; if (obs[1] !== e[1] || obs[1] !== 32'd3) $display("FAIL pause_stall: got %0d expected %0d", obs[1], e[1]); else n_pass++;
    endtask

    task automatic test_snap_race();
        snap_t obs, e;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0, 1, 0);
        tick(0, 1, 0, 0, 1, 1);
        n_total++; if (valid_w !== 1'b1) $display("FAIL race_valid: got %b expected 1", valid_w); else n_pass++;
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[3] !== e[3] || obs[3] !== 32'd4) $display("FAIL race_retire: got %0d expected %0d", obs[3], e[3]); else n_pass++;
        tick(0, 1, 0, 0, 0, 0);
        n_total++; if (valid_w !== 1'b0) $display("FAIL race_valid_drop: got %b expected 0", valid_w); else n_pass++;
        tick(0, 1, 0, 0, 0, 1);
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[3] !== e[3] || obs[3] !== 32'd5) $display("FAIL race_retire2: got %0d expected %0d", obs[3], e[3]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        snap_t obs, e;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, i[0], 0, 1, 1);
            n_total++; if (valid_w !== 1'b1) $display("FAIL b2b_valid%0d: got %b expected 1", i, valid_w); else n_pass++;
            sample(obs);
            if (exp_q.size() == 0) begin
                n_total++; $display("FAIL b2b_queue%0d: got empty expected entry", i);
            end else begin
                e = exp_q.pop_front();
                for (int k = 0; k < 4; k++) begin
                    n_total++;
                    if (obs[k] !== e[k]) $display("FAIL b2b_%0d_sel%0d: got %0d expected %0d", i, k, obs[k], e[k]); else n_pass++;
                end
            end
        end
        tick(0, 1, 0, 0, 0, 0);
        n_total++; if (valid_w !== 1'b0) $display("FAIL b2b_valid_end: got %b expected 0", valid_w); else n_pass++;
    endtask

    task automatic test_reset_mid();
        snap_t obs, e;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 0, 1, 0);
        tick(0, 1, 0, 0, 0, 1);
        tick(1, 1, 1, 1, 1, 1);
        n_total++; if (valid_w !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", valid_w); else n_pass++;
        n_total++; if (halt_w !== 1'b0) $display("FAIL rstmid_halt: got %b expected 0", halt_w); else n_pass++;
        n_total++; if (running_w !== 1'b0) $display("FAIL rstmid_running: got %b expected 0", running_w); else n_pass++;
        sample(obs);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (obs[k] !== 32'd0) $display("FAIL rstmid_shadow%0d: got %0d expected 0", k, obs[k]); else n_pass++;
        end
        tick(0, 0, 1, 1, 1, 1);
        n_total++; if (running_w !== 1'b0) $display("FAIL rstmid_idle: got %b expected 0", running_w); else n_pass++;
        sample(obs);
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (obs[k] !== e[k]) $display("FAIL rstmid_live%0d: got %0d expected %0d", k, obs[k], e[k]); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        snap_t obs, e;
        use4 = 1'b1; m_sat = 32'd15; m_max = 0;
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 1, 0, 0, 0);
            n_total++; if (halt_w !== 1'b0) $display("FAIL sat_halt%0d: got %b expected 0", i, halt_w); else n_pass++;
        end
        tick(0, 1, 1, 0, 0, 1);
        sample(obs);
        e = exp_q.pop_front();
        n_total++; if (obs[0] !== e[0] || obs[0] !== 32'd15) $display("FAIL sat_cycle: got %0d expected %0d", obs[0], e[0]); else n_pass++;
        n_total++; if (obs[1] !== e[1] || obs[1] !== 32'd15) $display("FAIL sat_stall: got %0d expected %0d", obs[1], e[1]); else n_pass++;
        n_total++; if (running_w !== 1'b1) $display("FAIL sat_running: got %b expected 1", running_w); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; retire = 1'b0; req = 1'b0;
        sel = 2'd0; use4 = 1'b0;
        m_sat = 32'hFFFF_FFFF; m_max = 30; m_state = IDLE; m_cnt = '0;
        test_reset();
        test_count_halt();
        test_events();
        test_pause();
        test_snap_race();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
